// File: rtl/render_pkg.sv
// Shared types and helpers for the render pipeline memory masters.
package render_pkg;

    typedef enum logic [1:0] {
        RM_IDLE  = 2'd0,
        RM_ISSUE = 2'd1,
        RM_DRAIN = 2'd2,
        RM_DONE  = 2'd3
    } rm_state_t;

    localparam int WORD_BYTES = 4;

    // Byte address of word idx; wraps silently modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [29:0] idx);
        return base + (32'(idx) * 32'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/read_credit_ctr.sv
// Outstanding-read counter and the issue credit check against the FIFO space.
module read_credit_ctr #(
    parameter int MAX_PENDING = 4,
    parameter int FIFO_DEPTH  = 256,
    parameter int USEDW_W     = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               accept,
    input  logic               retire,
    input  logic [USEDW_W-1:0] ff_usedw,
    output logic [3:0]         pending,
    output logic               can_issue
);

    localparam logic [31:0] MAX_P = 32'(MAX_PENDING);
    localparam logic [31:0] DEPTH = 32'(FIFO_DEPTH);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pending <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   pending <= pending + 4'd1;
                2'b01:   pending <= pending - 4'd1;
                default: pending <= pending;
            endcase
        end
    end

    // Every in-flight word already owns a FIFO slot, so usedw lag only over-counts.
    always_comb begin
        can_issue = (32'(pending) < MAX_P) && ((32'(pending) + 32'(ff_usedw)) < DEPTH);
    end

endmodule

// File: rtl/read_master.sv
// Avalon-MM pipelined read master streaming consecutive words into a FIFO.
//
// state    | meaning
// RM_IDLE  | waiting for start; latches address and word count
// RM_ISSUE | issuing reads while credits allow
// RM_DRAIN | all reads accepted, waiting for outstanding returns
// RM_DONE  | transfer complete; held until start falls
module read_master
    import render_pkg::*;
#(
    parameter int MAX_PENDING = 4,
    parameter int FIFO_DEPTH  = 256,
    parameter int USEDW_W     = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        length,
    input  logic [31:0]        start_address,
    output logic               RM_busy,
    output logic               RM_done,
    output logic               oRM_read,
    output logic [31:0]        oRM_readaddress,
    input  logic               iRM_waitrequest,
    input  logic [31:0]        iRM_readdata,
    input  logic               iRM_readdatavalid,
    output logic               FF_writerequest,
    output logic [31:0]        FF_data,
    input  logic [USEDW_W-1:0] FF_usedw
);

    rm_state_t   state;
    logic [31:0] base_address;
    logic [29:0] total_words;
    logic [29:0] issued;
    logic [3:0]  pending;
    logic        can_issue;
    logic        accept;
    logic        retire;
    logic        clear;
    logic        unused_len_lsb;

    assign unused_len_lsb = &{1'b0, length[1:0]};

    assign clear    = (state == RM_IDLE) && start;
    assign oRM_read = (state == RM_ISSUE) && can_issue;
    assign accept   = oRM_read && !iRM_waitrequest;
    assign retire   = iRM_readdatavalid && ((state == RM_ISSUE) || (state == RM_DRAIN));

    assign oRM_readaddress = oRM_read ? word_addr(base_address, issued) : 32'h0;
    assign FF_writerequest = retire;
    assign FF_data         = iRM_readdata;

    read_credit_ctr #(
        .MAX_PENDING (MAX_PENDING),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .USEDW_W     (USEDW_W)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .accept    (accept),
        .retire    (retire),
        .ff_usedw  (FF_usedw),
        .pending   (pending),
        .can_issue (can_issue)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RM_IDLE;
            base_address <= '0;
            total_words  <= '0;
            issued       <= '0;
            RM_busy      <= 1'b0;
            RM_done      <= 1'b0;
        end else begin
            case (state)
                RM_IDLE: begin
                    if (start) begin
                        base_address <= start_address;
                        total_words  <= length[31:2];
                        issued       <= '0;
                        if (length[31:2] == 30'd0) begin
                            state   <= RM_DONE;
                            RM_done <= 1'b1;
                        end else begin
                            state   <= RM_ISSUE;
                            RM_busy <= 1'b1;
                        end
                    end
                end
                RM_ISSUE: begin
                    if (accept) begin
                        issued <= issued + 30'd1;
                        if (issued == total_words - 30'd1) begin
                            state <= RM_DRAIN;
                        end
                    end
                end
                RM_DRAIN: begin
                    // A return landing this cycle counts toward completion.
                    if ((pending == 4'd0) || ((pending == 4'd1) && retire)) begin
                        state   <= RM_DONE;
                        RM_busy <= 1'b0;
                        RM_done <= 1'b1;
                    end
                end
                RM_DONE: begin
                    if (!start) begin
                        state   <= RM_IDLE;
                        RM_done <= 1'b0;
                    end
                end
                default: begin
                    state   <= RM_IDLE;
                    RM_busy <= 1'b0;
                    RM_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_master.sv
// Scoreboard bench for read_master with a 2-cycle-latency Avalon slave model.
module tb_read_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] length;
    logic [31:0] start_address;
    logic        RM_busy;
    logic        RM_done;
    logic        oRM_read;
    logic [31:0] oRM_readaddress;
    logic        wait_req = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        rdv = 1'b0;
    logic        FF_writerequest;
    logic [31:0] FF_data;
    logic [3:0]  usedw;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int acc_cnt, acc_first, acc_prev, last_rdv, done_cyc;
    int stall_at = 0;
    int stall_rem = 0;
    bit hold, drop, check_gap, done_seen;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          rtn_due[$];
    logic [31:0] rtn_data[$];

    read_master #(
        .MAX_PENDING (4),
        .FIFO_DEPTH  (8),
        .USEDW_W     (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .length            (length),
        .start_address     (start_address),
        .RM_busy           (RM_busy),
        .RM_done           (RM_done),
        .oRM_read          (oRM_read),
        .oRM_readaddress   (oRM_readaddress),
        .iRM_waitrequest   (wait_req),
        .iRM_readdata      (rdata),
        .iRM_readdatavalid (rdv),
        .FF_writerequest   (FF_writerequest),
        .FF_data           (FF_data),
        .FF_usedw          (usedw)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC3C3_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave drive: returns in order, one per cycle, plus scripted waitrequest.
    always @(posedge clk) begin
        cyc++;
        #2;
        rdv   = 1'b0;
        rdata = 32'h0;
        if (!hold && rtn_due.size() > 0 && rtn_due[0] <= cyc) begin
            rdv   = 1'b1;
            rdata = rtn_data.pop_front();
            void'(rtn_due.pop_front());
        end
        wait_req = (stall_rem > 0);
        if (stall_rem > 0) stall_rem--;
    end

    // Monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (oRM_read === 1'b1 && !wait_req) begin
            acc_cnt++;
            if (acc_cnt == 1) acc_first = cyc;
            else if (check_gap) chk("b2b_gap", cyc - acc_prev, 1);
            acc_prev = cyc;
            if (exp_addr.size() > 0) chk("rd_addr", oRM_readaddress, exp_addr.pop_front());
            else chk("extra_read", {31'h0, oRM_read}, 32'h0);
            exp_data.push_back(mem_word(oRM_readaddress));
            rtn_due.push_back(cyc + 2);
            rtn_data.push_back(mem_word(oRM_readaddress));
            if (acc_cnt == stall_at) stall_rem = 3;
        end
        if (wait_req && exp_addr.size() > 0) begin
            chk("stall_read", {31'h0, oRM_read}, 32'h1);
            chk("stall_addr", oRM_readaddress, exp_addr[0]);
        end
        if (rdv) begin
            last_rdv = cyc;
            if (drop) begin
                chk("late_rtn_dropped", {31'h0, FF_writerequest}, 32'h0);
            end else begin
                chk("ff_wr", {31'h0, FF_writerequest}, 32'h1);
                if (exp_data.size() > 0) chk("ff_data", FF_data, exp_data.pop_front());
                else chk("ff_unexpected", {31'h0, FF_writerequest}, 32'h0);
            end
        end
        if (RM_done === 1'b1 && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    task automatic begin_xfer(input logic [31:0] addr, input logic [31:0] len, input int nexp, output int t0);
        acc_cnt   = 0;
        done_seen = 1'b0;
        for (int i = 0; i < nexp; i++) exp_addr.push_back(addr + 32'(4 * i));
        start_address = addr;
        length        = len;
        start         = 1'b1;
        t0            = cyc;
        tick();
        if (nexp > 0) chk("busy", {31'h0, RM_busy}, 32'h1);
    endtask

    task automatic finish_xfer(input int nexp, input int t0);
        for (int n = 0; n < 200 && !done_seen; n++) tick();
        chk("done_seen", {31'h0, done_seen}, 32'h1);
        chk("accepts", acc_cnt, nexp);
        chk("addr_q_empty", exp_addr.size(), 0);
        chk("data_q_empty", exp_data.size(), 0);
        if (nexp > 0) begin
            chk("first_rd_lat", acc_first - t0, 1);
            chk("done_lat", done_cyc - last_rdv, 1);
        end
        chk("busy_in_done", {31'h0, RM_busy}, 32'h0);
        start = 1'b0;
        tick();
        chk("done_cleared", {31'h0, RM_done}, 32'h0);
    endtask

    task automatic run_xfer(input logic [31:0] addr, input logic [31:0] len, input int nexp, input bit gap);
        int t0;
        check_gap = gap;
        begin_xfer(addr, len, nexp, t0);
        finish_xfer(nexp, t0);
        check_gap = 1'b0;
    endtask

    task automatic zero_len(input logic [31:0] len);
        acc_cnt       = 0;
        start_address = 32'h5000_0000;
        length        = len;
        start         = 1'b1;
        tick();
        chk("zl_done_t1", {31'h0, RM_done}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("zl_done_held", {31'h0, RM_done}, 32'h1);
        end
        start = 1'b0;
        tick();
        chk("zl_idle", {31'h0, RM_done}, 32'h0);
        chk("zl_no_read", acc_cnt, 0);
    endtask

    initial begin
        int t0;
        rst = 1'b1; start = 1'b0; length = '0; start_address = '0; usedw = '0;
        hold = 1'b0; drop = 1'b0; check_gap = 1'b0; done_seen = 1'b0;
        acc_cnt = 0; acc_first = 0; acc_prev = 0; last_rdv = 0; done_cyc = 0;
        repeat (3) tick();
        chk("rst_read", {31'h0, oRM_read}, 32'h0);
        chk("rst_addr", oRM_readaddress, 32'h0);
        chk("rst_ffwr", {31'h0, FF_writerequest}, 32'h0);
        chk("rst_busy", {31'h0, RM_busy}, 32'h0);
        chk("rst_done", {31'h0, RM_done}, 32'h0);
        rst = 1'b0;
        tick();

        // Basic transfer, back-to-back reads
        run_xfer(32'h1000_0000, 32'd16, 4, 1'b1);

        // Wait-request stall on the second read
        stall_at = 1;
        run_xfer(32'h1000_0000, 32'd16, 4, 1'b0);
        stall_at = 0;

        // FIFO backpressure: only two credits with usedw=6 of 8
        usedw = 4'd6;
        hold  = 1'b1;
        begin_xfer(32'h0000_2000, 32'd16, 4, t0);
        repeat (8) tick();
        chk("bp_accepts", acc_cnt, 2);
        chk("bp_read_low", {31'h0, oRM_read}, 32'h0);
        hold = 1'b0;
        finish_xfer(4, t0);
        usedw = 4'd0;

        // Zero-length, including ignored length[1:0]
        zero_len(32'd0);
        zero_len(32'd3);

        // Address wrap
        run_xfer(32'hFFFF_FFF8, 32'd16, 4, 1'b1);

        // Reset with two reads outstanding
        usedw = 4'd6;
        hold  = 1'b1;
        begin_xfer(32'h0000_3000, 32'd32, 8, t0);
        repeat (6) tick();
        chk("pre_rst_accepts", acc_cnt, 2);
        start = 1'b0;
        rst   = 1'b1;
        tick();
        chk("mrst_read", {31'h0, oRM_read}, 32'h0);
        chk("mrst_addr", oRM_readaddress, 32'h0);
        chk("mrst_ffwr", {31'h0, FF_writerequest}, 32'h0);
        chk("mrst_busy", {31'h0, RM_busy}, 32'h0);
        chk("mrst_done", {31'h0, RM_done}, 32'h0);
        rst   = 1'b0;
        usedw = 4'd0;
        drop  = 1'b1;
        hold  = 1'b0;
        repeat (6) tick();
        chk("post_rst_no_read", acc_cnt, 2);
        chk("late_rtn_delivered", rtn_due.size(), 0);
        drop = 1'b0;
        exp_addr.delete();
        exp_data.delete();

        // Recovery after reset
        run_xfer(32'h0000_4000, 32'd8, 2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
